// File: rtl/mem_bist_initiator_if.sv
// rtl/mem_bist_initiator_if.sv - valid/ready request bus between the BIST initiator and a single-port memory
// Signal suffixes are from the initiator's point of view.
interface mem_bist_initiator_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  valid_o;
  logic                  w_r_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WIDTH-1:0]      wdata_o;
  logic                  ready_i;
  logic [WIDTH-1:0]      rdata_i;

  modport master (
    output valid_o,
    output w_r_o,
    output addr_o,
    output wdata_o,
    input  ready_i,
    input  rdata_i
  );

  modport slave (
    input  valid_o,
    input  w_r_o,
    input  addr_o,
    input  wdata_o,
    output ready_i,
    output rdata_i
  );
endinterface

// File: rtl/mem_bist_initiator.sv
// rtl/mem_bist_initiator.sv - writes a seed+idx pattern over a wrapping window, reads it back and scores it
// Optional handshake watchdog: define MEMBIST_TIMEOUT_EN.
module mem_bist_initiator #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o,
  mem_bist_initiator_if.master  mem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic                  valid_q, valid_d;
  logic                  w_r_q, w_r_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0]      exp_data;
  logic                  wd_expired;
  logic                  in_wr;
  logic                  in_xfer;

  // Window addresses wrap for free because DEPTH is a power of two.
  assign cur_addr = base_q + idx_q;
  assign exp_data = seed_q + WIDTH'(idx_q);

`ifdef MEMBIST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT - 1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wd_expired = (cnt_q == CNT_W'(TIMEOUT - 1)) &&
                      (state_q != IDLE) && (state_q != DONE);
`else
  localparam int unused_timeout = TIMEOUT;

  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    len_d       = len_q;
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d      = base_i;
          len_d       = len_i;
          seed_d      = seed_i;
          idx_d       = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          state_d     = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem.ready_i) begin
          state_d = WR_GAP;
        end
      end
      WR_GAP: begin
        // A ready still high here belongs to the request just retired.
        if (!mem.ready_i) begin
          if (idx_q < len_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = WR_REQ;
          end else begin
            idx_d   = '0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (mem.ready_i) begin
          state_d = RD_GAP;
          if (mem.rdata_i != exp_data) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
              first_err_d = cur_addr;
            end
          end
        end
      end
      RD_GAP: begin
        if (!mem.ready_i) begin
          if (idx_q < len_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == '0) && !timeout_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An abort freezes the scoreboard exactly as it stood.
    if (wd_expired) begin
      state_d     = DONE;
      timeout_d   = 1'b1;
      idx_d       = idx_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
    end

    in_wr   = (state_d == WR_REQ) || (state_d == WR_GAP);
    in_xfer = in_wr || (state_d == RD_REQ) || (state_d == RD_GAP);
    valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    w_r_d   = in_wr;
    addr_d  = in_xfer ? (base_d + idx_d) : '0;
    wdata_d = in_wr ? (seed_d + WIDTH'(idx_d)) : '0;
    busy_d  = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      w_r_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      w_r_q       <= w_r_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign timeout_o        = timeout_q;

  assign mem.valid_o = valid_q;
  assign mem.w_r_o   = w_r_q;
  assign mem.addr_o  = addr_q;
  assign mem.wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// tb/tb_mem_bist_initiator.sv - randomized self-checking bench for mem_bist_initiator against a behavioural memory
`timescale 1ns/1ps
module tb_mem_bist_initiator;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [AW-1:0] len_i = '0;
  logic [W-1:0]  seed_i = '0;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [AW:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o;

  mem_bist_initiator_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_bist_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .base_i           (base_i),
    .len_i            (len_i),
    .seed_i           (seed_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o),
    .timeout_o        (timeout_o),
    .mem              (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with per-address read fault injection.
  logic [W-1:0] mem_arr [D];
  bit           fault [D];
  bit           scramble = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready_i <= 1'b0;
      bus.rdata_i <= '0;
    end else if (scramble) begin
      for (int i = 0; i < D; i++) mem_arr[i] <= W'($urandom);
      bus.ready_i <= 1'b0;
    end else if (bus.valid_o) begin
      if (bus.w_r_o) mem_arr[bus.addr_o] <= bus.wdata_o;
      else bus.rdata_i <= mem_arr[bus.addr_o] ^ W'(fault[bus.addr_o]);
      bus.ready_i <= 1'b1;
    end else begin
      bus.ready_i <= 1'b0;
    end
  end

  int   cyc = 0;
  int   req_cnt = 0;
  int   gap_viol = 0;
  int   done_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_o && !prev_valid) begin
      req_cnt++;
      if (bus.ready_i) gap_viol++;
    end
    if (done_o) done_cnt++;
    prev_valid = bus.valid_o;
  end

  int total = 0;
  int bad = 0;
  int t0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_mem();
    @(negedge clk); scramble = 1'b1;
    @(negedge clk); scramble = 1'b0;
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] l,
                           input logic [W-1:0] s, input bit hold);
    @(negedge clk);
    base_i = b; len_i = l; seed_i = s; start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int at);
    at = -1;
    for (int k = 0; k < 400 && at < 0; k++) begin
      @(negedge clk);
      if (done_o) at = cyc;
    end
    if (at < 0) check({tag, "_done_seen"}, done_o, 1);
  endtask

  task automatic full_run(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input logic [W-1:0] s);
    logic [W-1:0] exp_mem [D];
    int at, n, exp_err, exp_first, a;
    exp_mem = mem_arr;
    n = int'(l) + 1;
    exp_err = 0;
    exp_first = 0;
    for (int i = 0; i < n; i++) begin
      a = (int'(b) + i) % D;
      exp_mem[a] = W'(int'(s) + i);
      if (fault[a]) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    start_run(b, l, s, 0);
    check({tag, "_busy_start"}, busy_o, 1);
    wait_done(tag, at);
    check({tag, "_latency"}, at - t0, 8 * n + 2);
    check({tag, "_pass"}, pass_o, (exp_err == 0) ? 1 : 0);
    check({tag, "_err_cnt"}, err_cnt_o, exp_err);
    check({tag, "_first_err"}, first_err_addr_o, exp_first);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_busy_at_done"}, busy_o, 1);
    @(negedge clk);
    check({tag, "_done_single"}, done_o, 0);
    check({tag, "_busy_after"}, busy_o, 0);
    check({tag, "_pass_hold"}, pass_o, (exp_err == 0) ? 1 : 0);
    for (int i = 0; i < D; i++) check($sformatf("%s_mem%0d", tag, i), mem_arr[i], exp_mem[i]);
  endtask

  initial begin
    int at1, at2, d0, r0, found;
    logic [AW-1:0] rb, rl;
    logic [W-1:0] rs;

    for (int i = 0; i < D; i++) fault[i] = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pass", pass_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_first", first_err_addr_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_w_r", bus.w_r_o, 0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_wdata", bus.wdata_o, 0);
    @(negedge clk); rst = 1'b0;

    scramble_mem();
    full_run("full", 4'd0, 4'd15, 16'h1000);

    scramble_mem();
    full_run("wrap", 4'd14, 4'd3, 16'hFFFE);

    scramble_mem();
    fault[5] = 1'b1; fault[9] = 1'b1;
    full_run("fault", 4'd0, 4'd15, 16'h5A5A);
    fault[5] = 1'b0; fault[9] = 1'b0;

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < D; i++) fault[i] = ($urandom_range(0, 3) == 0);
      rb = AW'($urandom); rl = AW'($urandom); rs = W'($urandom);
      scramble_mem();
      full_run($sformatf("rand%0d", r), rb, rl, rs);
    end
    for (int i = 0; i < D; i++) fault[i] = 1'b0;

    // start held across two runs: one run per IDLE entry, back to back
    repeat (3) @(negedge clk);
    d0 = done_cnt; r0 = req_cnt;
    start_run(4'd6, 4'd3, 16'h0123, 1);
    wait_done("hold1", at1);
    check("hold1_latency", at1 - t0, 8 * 4 + 2);
    wait_done("hold2", at2);
    start_i = 1'b0;
    check("hold2_period", at2 - at1, 8 * 4 + 2);
    check("hold2_pass", pass_o, 1);
    repeat (40) @(negedge clk);
    check("hold_done_count", done_cnt - d0, 2);
    check("hold_req_count", req_cnt - r0, 2 * 2 * 4);
    check("hold_idle_busy", busy_o, 0);

    // asynchronous reset in the middle of RD_REQ idx=7
    fault[2] = 1'b1;
    start_run(4'd0, 4'd15, 16'hBEEF, 0);
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge clk);
      if (bus.valid_o && !bus.w_r_o && bus.addr_o == 4'd7) found = 1;
    end
    check("mid_found_rd7", found, 1);
    check("mid_err_before", err_cnt_o, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_busy", busy_o, 0);
    check("mid_done", done_o, 0);
    check("mid_pass", pass_o, 0);
    check("mid_err_cnt", err_cnt_o, 0);
    check("mid_first", first_err_addr_o, 0);
    check("mid_timeout", timeout_o, 0);
    check("mid_valid", bus.valid_o, 0);
    check("mid_w_r", bus.w_r_o, 0);
    check("mid_addr", bus.addr_o, 0);
    check("mid_wdata", bus.wdata_o, 0);
    @(negedge clk); rst = 1'b0;
    fault[2] = 1'b0;
    scramble_mem();
    full_run("post_rst", 4'd3, 4'd15, W'($urandom));

    check("gap_request_violations", gap_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1);
  end

endmodule
